// File: rtl/occupancy_map_builder.sv
// Builds white/black occupancy bitboards from packed piece locations, scanning one piece pair per
// clock from a snapshot taken at start; also flags dead kings and square collisions.
module occupancy_map_builder #(
  parameter int unsigned SQ_W   = 6,
  parameter int unsigned PIECES = 16
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     start,
  input  logic [SQ_W*PIECES-1:0]   location_vectors_w,
  input  logic [SQ_W*PIECES-1:0]   location_vectors_b,
  input  logic [PIECES-1:0]        alive_vectors_w,
  input  logic [PIECES-1:0]        alive_vectors_b,
  output logic [(1<<SQ_W)-1:0]     occ_w,
  output logic [(1<<SQ_W)-1:0]     occ_b,
  output logic                     busy,
  output logic                     valid,
  output logic                     king_dead_w,
  output logic                     king_dead_b,
  output logic                     collision
);

  localparam int unsigned NSQ = 1 << SQ_W;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StScan    = 2'd1;
  localparam logic [1:0] StPublish = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [SQ_W*PIECES-1:0] loc_w_q, loc_w_d, loc_b_q, loc_b_d;
  logic [PIECES-1:0]      alive_w_q, alive_w_d, alive_b_q, alive_b_d;
  logic [NSQ-1:0]         work_w_q, work_w_d, work_b_q, work_b_d;
  logic                   coll_work_q, coll_work_d;
  logic [NSQ-1:0]         occ_w_q, occ_w_d, occ_b_q, occ_b_d;
  logic                   valid_q, valid_d;
  logic                   kd_w_q, kd_w_d, kd_b_q, kd_b_d;
  logic                   coll_q, coll_d;

  logic [SQ_W-1:0]        sq_w, sq_b;
  logic                   al_w, al_b;

  assign sq_w = loc_w_q[SQ_W*cnt_q +: SQ_W];
  assign sq_b = loc_b_q[SQ_W*cnt_q +: SQ_W];
  assign al_w = alive_w_q[cnt_q];
  assign al_b = alive_b_q[cnt_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    loc_w_d     = loc_w_q;
    loc_b_d     = loc_b_q;
    alive_w_d   = alive_w_q;
    alive_b_d   = alive_b_q;
    work_w_d    = work_w_q;
    work_b_d    = work_b_q;
    coll_work_d = coll_work_q;
    occ_w_d     = occ_w_q;
    occ_b_d     = occ_b_q;
    kd_w_d      = kd_w_q;
    kd_b_d      = kd_b_q;
    coll_d      = coll_q;
    valid_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          loc_w_d     = location_vectors_w;
          loc_b_d     = location_vectors_b;
          alive_w_d   = alive_vectors_w;
          alive_b_d   = alive_vectors_b;
          work_w_d    = '0;
          work_b_d    = '0;
          coll_work_d = 1'b0;
          cnt_d       = 4'd0;
          state_d     = StScan;
        end
      end
      StScan: begin
        // Collision tests use the bitboards as they stood before this edge; the same-cycle
        // white/black overlap is caught separately.
        if (al_w) begin
          if (work_w_q[sq_w] || work_b_q[sq_w]) coll_work_d = 1'b1;
          work_w_d[sq_w] = 1'b1;
        end
        if (al_b) begin
          if (work_w_q[sq_b] || work_b_q[sq_b]) coll_work_d = 1'b1;
          work_b_d[sq_b] = 1'b1;
        end
        if (al_w && al_b && (sq_w == sq_b)) coll_work_d = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = StPublish;
      end
      StPublish: begin
        occ_w_d = work_w_q;
        occ_b_d = work_b_q;
        coll_d  = coll_work_q;
        kd_w_d  = ~alive_w_q[0];
        kd_b_d  = ~alive_b_q[0];
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      loc_w_q     <= '0;
      loc_b_q     <= '0;
      alive_w_q   <= '0;
      alive_b_q   <= '0;
      work_w_q    <= '0;
      work_b_q    <= '0;
      coll_work_q <= 1'b0;
      occ_w_q     <= '0;
      occ_b_q     <= '0;
      kd_w_q      <= 1'b0;
      kd_b_q      <= 1'b0;
      coll_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loc_w_q     <= loc_w_d;
      loc_b_q     <= loc_b_d;
      alive_w_q   <= alive_w_d;
      alive_b_q   <= alive_b_d;
      work_w_q    <= work_w_d;
      work_b_q    <= work_b_d;
      coll_work_q <= coll_work_d;
      occ_w_q     <= occ_w_d;
      occ_b_q     <= occ_b_d;
      kd_w_q      <= kd_w_d;
      kd_b_q      <= kd_b_d;
      coll_q      <= coll_d;
      valid_q     <= valid_d;
    end
  end

  assign occ_w       = occ_w_q;
  assign occ_b       = occ_b_q;
  assign busy        = (state_q != StIdle);
  assign valid       = valid_q;
  assign king_dead_w = kd_w_q;
  assign king_dead_b = kd_b_q;
  assign collision   = coll_q;

endmodule

// File: doc/occupancy_map_builder.md
OCCUPANCY_MAP_BUILDER -- requirements
Module: occupancy_map_builder

Interface
REQ-001 Parameter: SQ_W, 6, square-index width; only 6 is supported.
REQ-002 Parameter: PIECES, 16, pieces per colour; only 16 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request pulse; the board updater's done is connected here.
REQ-006 location_vectors_w  input  96  white squares; piece i occupies bits [6i+5:6i]; K1=0, Q1=1, B2..B1=2..3, N2..N1=4..5, R2..R1=6..7, P8..P1=8..15.
REQ-007 location_vectors_b  input  96  black squares; same packing as white.
REQ-008 alive_vectors_w  input  16  white alive bits; bit i belongs to piece i.
REQ-009 alive_vectors_b  input  16  black alive bits; bit i belongs to piece i.
REQ-010 occ_w  output  64  white occupancy bitboard; bit s set means an alive white piece is on square s.
REQ-011 occ_b  output  64  black occupancy bitboard.
REQ-012 busy  output  1  high while a scan is in progress.
REQ-013 valid  output  1  one-cycle pulse when new results are published.
REQ-014 king_dead_w  output  1  alive_vectors_w[0] was 0 in the snapshot.
REQ-015 king_dead_b  output  1  alive_vectors_b[0] was 0 in the snapshot.
REQ-016 collision  output  1  two alive pieces shared a square in the snapshot.

Function
REQ-017 FSM states SHALL be IDLE, SCAN and PUBLISH.
REQ-018 IDLE -> SCAN on a clock edge with start=1; on that edge all four input vectors SHALL be captured into snapshot registers, the working bitboards and the collision flag SHALL be cleared, and the counter SHALL be set to 0.
REQ-019 In SCAN, each edge SHALL process white piece cnt and black piece cnt from the snapshot: an alive piece sets bit <square> in its working bitboard, and a dead piece changes nothing.
REQ-020 Collision is sticky for the scan and SHALL be set when an alive piece's target bit is already set in either working bitboard, or when white cnt and black cnt are both alive on the same square in the same cycle.
REQ-021 The counter SHALL be 4 bits wide and SHALL increment each SCAN edge; the edge that processes cnt=15 SHALL move the FSM to PUBLISH (no wrap into a second pass).
REQ-022 The PUBLISH edge SHALL copy the working bitboards to occ_w/occ_b, load collision and king_dead_w/b, assert valid for exactly one cycle, and return the FSM to IDLE.
REQ-023 Latency: valid SHALL be high in the cycle following the 17th edge after the edge that sampled start.
REQ-024 busy SHALL be 1 in SCAN and PUBLISH and 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored; there is no queuing.
REQ-026 start in the same cycle as PUBLISH SHALL be ignored; it is accepted only from IDLE.
REQ-027 Input changes after the start edge SHALL NOT affect the in-flight result.
REQ-028 occ_w, occ_b, king_dead_*, and collision SHALL hold their last published values between valid pulses.

Reset
REQ-029 RST=1 SHALL immediately (asynchronously) force: state IDLE, counter 0, snapshots 0, occ_w=0, occ_b=0, busy=0, valid=0, king_dead_w=0, king_dead_b=0, collision=0.
REQ-030 RST asserted mid-scan SHALL abort the scan with no valid pulse afterward; the first start after RST release SHALL begin a fresh scan.

Verification
REQ-031 Reset: assert RST asynchronously -> all outputs 0 before the next clock edge.
REQ-032 Initial board (white 0x20928B30D38F0070460850C4, black 0xC31CB3D35DB7E3FE7EEBDEFC, alive 0xFFFF/0xFFFF), start pulse -> busy for 17 cycles, then valid=1 for one cycle with occ_w=0x000000000000FFFF, occ_b=0xFFFF000000000000, collision=0, king_dead_w=0, king_dead_b=0.
REQ-033 Same board, alive_w=0xFFFE -> occ_w=0x000000000000FFEF, king_dead_w=1, king_dead_b=0.
REQ-034 White P1 (bits 95:90) set to 48 with black P1 alive on 48 -> collision=1, occ_w bit 48 set, occ_w bit 8 clear; with alive_b[15]=0 instead -> collision=0 and occ_b bit 48 clear.
REQ-035 Second start pulse and input changes at cycles 3-10 of a scan -> exactly one valid pulse, with results matching the original snapshot.
REQ-036 RST pulsed at scan cycle 8 -> no valid pulse; a subsequent start produces the correct result 17 edges later.
